// File: rtl/tlul_fuzz_host.sv
// tlul_fuzz_host: req/gnt host bus to TL-UL adapter with in-flight tracking and response checking
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
  } tl_a_user_t;
  parameter tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'h0, instr_type: 4'h9};
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_fuzz_host
  import tlul_pkg::*;
#(
  parameter int MaxReqs = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);
  localparam int OW = $clog2(MaxReqs + 1);
  localparam int SW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam logic [OW-1:0] MAX_O = OW'(MaxReqs);
  localparam logic [SW-1:0] LAST_S = SW'(MaxReqs - 1);

  logic [OW-1:0] outst_q, outst_d;
  logic [SW-1:0] src_q, src_d, exp_q, exp_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          full, a_valid, a_hs, d_hs, d_acc;
  logic          unused_tl;

  assign full    = outst_q == MAX_O;
  assign a_valid = req_i && !full;
  assign a_hs    = a_valid && tl_i.a_ready;
  assign d_hs    = tl_i.d_valid;
  assign d_acc   = d_hs && (outst_q != '0);
  assign gnt_o   = a_hs;
  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, addr_i[1:0]};

  // A-channel request built directly from the host payload; D channel always accepted
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = we_i ? ((be_i == 4'hF) ? PutFullData : PutPartialData) : Get;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'(src_q);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  // next state: in-flight count, rotating IDs, and response capture (spurious beats leave counters alone)
  always_comb begin
    outst_d = (a_hs && !d_acc) ? outst_q + OW'(1) : (!a_hs && d_acc) ? outst_q - OW'(1) : outst_q;
    src_d   = a_hs ? ((src_q == LAST_S) ? '0 : src_q + SW'(1)) : src_q;
    exp_d   = d_acc ? ((exp_q == LAST_S) ? '0 : exp_q + SW'(1)) : exp_q;
    valid_d = d_hs;
    rdata_d = d_hs ? ((tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0) : rdata_q;
    err_d   = d_hs ? (tl_i.d_error || (tl_i.d_source != 8'(exp_q)) || (outst_q == '0)) : err_q;
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
      src_q   <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      src_q   <= src_d;
      exp_q   <= exp_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_tlul_fuzz_host.sv
// tb_tlul_fuzz_host: directed bench with a transaction-level reference model for tlul_fuzz_host
module tb_tlul_fuzz_host;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst_ni;
  logic req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0] be_i;
  logic gnt_o, valid_o, err_o;
  logic [31:0] rdata_o;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;

  int checks = 0;
  int errors = 0;

  int q[$];
  int grants;
  logic m_valid, m_err;
  logic [31:0] m_rdata;
  bit m_g;
  int g;

  tlul_fuzz_host #(.MaxReqs(MR)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .valid_o(valid_o),
    .rdata_o(rdata_o), .err_o(err_o), .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = b;
  endtask

  task automatic set_d(input bit v, input bit dat, input logic [7:0] s, input logic [31:0] d, input bit e);
    tl_i.d_valid  = v;
    tl_i.d_opcode = dat ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
    tl_i.d_source = s;
    tl_i.d_data   = d;
    tl_i.d_error  = e;
  endtask

  // transaction model: in-flight requests are a queue of source IDs, responses must pop them in order
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      grants = 0; m_valid = 0; m_rdata = 0; m_err = 0;
    end else begin
      m_g = req_i && (q.size() < MR) && tl_i.a_ready;
      m_valid = tl_i.d_valid;
      if (tl_i.d_valid) begin
        m_rdata = (tl_i.d_opcode == tlul_pkg::AccessAckData) ? tl_i.d_data : 32'h0;
        m_err = tl_i.d_error || ((q.size() == 0) ? 1'b1 : (int'(tl_i.d_source) != q[0]));
        if (q.size() != 0) void'(q.pop_front());
      end
      if (m_g) begin
        q.push_back(grants % MR);
        grants++;
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("gnt", gnt_o, req_i && (q.size() < MR) && tl_i.a_ready);
    chk("a_valid", tl_o.a_valid, req_i && (q.size() < MR));
    chk("d_ready", tl_o.d_ready, 1);
    chk("valid", valid_o, m_valid);
    if (m_valid) begin
      chk("rdata", rdata_o, m_rdata);
      chk("err", err_o, m_err);
    end
    if (tl_o.a_valid) begin
      chk("a_source", tl_o.a_source, grants % MR);
      chk("a_opcode", tl_o.a_opcode, we_i ? ((be_i == 4'hF) ? 0 : 1) : 4);
      chk("a_mask", tl_o.a_mask, we_i ? be_i : 4'hF);
      chk("a_address", tl_o.a_address, addr_i & 32'hFFFF_FFFC);
      chk("a_data", tl_o.a_data, we_i ? wdata_i : 0);
      chk("a_size", tl_o.a_size, 2);
      chk("a_param", tl_o.a_param, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    tl_i = '0;
    tl_i.a_ready = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_d(0, 0, 0, 0, 0);
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_a_valid", tl_o.a_valid, 0);
    chk("rst_d_ready", tl_o.d_ready, 1);
    step(); step();
    rst_ni = 1'b1;
    // write then read back
    set_req(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    chk("wr_gnt", gnt_o, 1);
    chk("wr_op", tl_o.a_opcode, 0);
    chk("wr_src", tl_o.a_source, 0);
    step();
    set_req(1, 0, 32'h10, 0, 0);
    #1;
    chk("rd_gnt", gnt_o, 1);
    chk("rd_op", tl_o.a_opcode, 4);
    chk("rd_src", tl_o.a_source, 1);
    step();
    set_req(0, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0);
    step();
    chk("wr_rsp_valid", valid_o, 1);
    chk("wr_rsp_err", err_o, 0);
    set_d(1, 1, 1, 32'hDEADBEEF, 0);
    step();
    chk("rd_rsp_valid", valid_o, 1);
    chk("rd_rsp_rdata", rdata_o, 32'hDEADBEEF);
    chk("rd_rsp_err", err_o, 0);
    set_d(0, 0, 0, 0, 0);
    step();
    chk("pulse_end", valid_o, 0);
    // partial write
    set_req(1, 1, 32'h13, 32'hCAFE0011, 4'b0011);
    #1;
    chk("pw_op", tl_o.a_opcode, 1);
    chk("pw_mask", tl_o.a_mask, 3);
    chk("pw_addr", tl_o.a_address, 32'h10);
    chk("pw_src", tl_o.a_source, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("pw_rsp_err", err_o, 0);
    // backpressure: device withholds D for 10 cycles
    set_req(1, 0, 32'h20, 0, 0);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      g += int'(gnt_o);
      if (i >= 2) chk("bp_blocked", gnt_o, 0);
      step();
    end
    chk("bp_grants", g, 2);
    set_d(1, 1, 1, 32'h1111, 0);
    #1;
    chk("bp_beat_gnt", gnt_o, 0);
    step();
    set_d(0, 0, 0, 0, 0);
    #1;
    chk("bp_third_gnt", gnt_o, 1);
    chk("bp_third_src", tl_o.a_source, 1);
    chk("bp_rsp_err", err_o, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    set_d(1, 1, 0, 32'h2222, 0);
    step();
    chk("bp_drain0_err", err_o, 0);
    set_d(1, 1, 1, 32'h3333, 0);
    step();
    chk("bp_drain1_err", err_o, 0);
    set_d(0, 0, 0, 0, 0);
    step();
    // d_error propagation
    set_req(1, 0, 32'h30, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0);
    set_d(1, 1, 0, 0, 1);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("derr_valid", valid_o, 1);
    chk("derr_err", err_o, 1);
    // wrong source: 1 arrives when 0 is expected
    set_req(1, 0, 32'h34, 0, 0);
    step(); step();
    set_req(0, 0, 0, 0, 0);
    set_d(1, 1, 1, 0, 0);
    step();
    chk("src_ok_err", err_o, 0);
    set_d(1, 1, 1, 0, 0);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("src_bad_err", err_o, 1);
    // unsolicited beat with nothing in flight
    set_d(1, 1, 1, 0, 0);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("spur_valid", valid_o, 1);
    chk("spur_err", err_o, 1);
    set_req(1, 0, 32'h40, 0, 0);
    g = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      g += int'(gnt_o);
      step();
    end
    chk("spur_outst", g, 2);
    set_req(0, 0, 0, 0, 0);
    set_d(1, 1, 1, 0, 0);
    step();
    chk("spur_exp0_err", err_o, 0);
    set_d(1, 1, 0, 0, 0);
    step();
    chk("spur_exp1_err", err_o, 0);
    set_d(0, 0, 0, 0, 0);
    step();
    // reset with two requests outstanding
    set_req(1, 0, 32'h50, 0, 0);
    step(); step();
    set_d(1, 1, 1, 32'h5A5A5A5A, 1);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("pre_rst_valid", valid_o, 1);
    chk("pre_rst_rdata", rdata_o, 32'h5A5A5A5A);
    chk("pre_rst_err", err_o, 1);
    step();
    set_req(0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_a_valid", tl_o.a_valid, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_d_ready", tl_o.d_ready, 1);
    step();
    rst_ni = 1'b1;
    set_d(1, 1, 0, 32'h77, 0);
    step();
    set_d(0, 0, 0, 0, 0);
    chk("late_valid", valid_o, 1);
    chk("late_err", err_o, 1);
    // wrap-around of source IDs, first grant after reset uses 0
    for (int i = 0; i < 5; i++) begin
      set_req(1, 0, 32'h100 + 32'(i * 4), 0, 0);
      #1;
      chk("wrap_gnt", gnt_o, 1);
      chk("wrap_src", tl_o.a_source, i % 2);
      step();
      set_req(0, 0, 0, 0, 0);
      set_d(1, 1, 8'(i % 2), 32'h100 + 32'(i), 0);
      step();
      set_d(0, 0, 0, 0, 0);
      chk("wrap_valid", valid_o, 1);
      chk("wrap_err", err_o, 0);
      chk("wrap_rdata", rdata_o, 32'h100 + 32'(i));
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
